// File: rtl/eth_cdc_pkg.sv
// Shared definitions for the MAC-side ingress arbiter in front of slow_fast_cdc.
// Holds the header magic nibble, the arbiter state type and the counter width.
package eth_cdc_pkg;

    localparam logic [3:0] HDR_MAGIC   = 4'hA;
    localparam int         MAX_NUM_SRC = 16;
    localparam int         TRUNC_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        DRAIN,
        GAP
    } arb_state_t;

    // Frame prefix byte: magic in the high nibble, source index in the low.
    function automatic logic [7:0] mkHeader(input logic [3:0] idx);
        return {HDR_MAGIC, idx};
    endfunction

endpackage

// File: rtl/cdc_ingress_arbiter_rr_picker.sv
// rr_picker: combinational requester search over NUM_SRC request bits.
// Ports: reqIn (requests), ptrIn (last winner), foundOut, idxOut (winner).
// Macro ARB_STRICT_PRIO_EN selects lowest-index-wins and ignores ptrIn;
// otherwise the search starts at ptrIn+1 modulo NUM_SRC.
module rr_picker
    import eth_cdc_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_SRC-1:0] reqIn,
    input  logic [IDX_W-1:0]   ptrIn,
    output logic               foundOut,
    output logic [IDX_W-1:0]   idxOut
);

`ifdef ARB_STRICT_PRIO_EN
    logic unusedPtr;
    assign unusedPtr = ^ptrIn;

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        foundOut = 1'b0;
        idxOut   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (reqIn[IDX_W'(k)]) begin
                foundOut = 1'b1;
                idxOut   = IDX_W'(k);
            end
        end
    end
`else
    int cand;

    // Offset NUM_SRC is the previous winner itself (lowest priority);
    // offset 1 is written last and therefore wins.
    always_comb begin
        foundOut = 1'b0;
        idxOut   = '0;
        cand     = 0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = (int'(ptrIn) + k) % NUM_SRC;
            if (reqIn[IDX_W'(cand)]) begin
                foundOut = 1'b1;
                idxOut   = IDX_W'(cand);
            end
        end
    end
`endif

endmodule

// File: rtl/cdc_ingress_arbiter.sv
// cdc_ingress_arbiter: frame-granular arbiter sharing the CDC byte write port.
// Ports: wrClkIn/wrRstIn (sync, active-high), srcValidIn/srcLastIn/srcDataIn/
// srcReadyOut per source, wrEnOut/wrDataOut to the CDC, busyOut, truncCntOut.
// Frames get a {HDR_MAGIC,idx} prefix, are cut at MAX_LEN data bytes and are
// separated by GAP_CYCLES idle cycles. Macro ARB_STRICT_PRIO_EN: fixed priority.
module cdc_ingress_arbiter
    import eth_cdc_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int MAX_LEN    = 1518,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   wrClkIn,
    input  logic                   wrRstIn,
    input  logic [NUM_SRC-1:0]     srcValidIn,
    input  logic [NUM_SRC-1:0]     srcLastIn,
    input  logic [8*NUM_SRC-1:0]   srcDataIn,
    output logic [NUM_SRC-1:0]     srcReadyOut,
    output logic                   wrEnOut,
    output logic [7:0]             wrDataOut,
    output logic                   busyOut,
    output logic [TRUNC_CNT_W-1:0] truncCntOut
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam arb_state_t END_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

    arb_state_t       state;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] rrPtr;
    logic [15:0]      lenCnt;
    logic [7:0]       gapCnt;

    logic             pickFound;
    logic [IDX_W-1:0] pickIdx;

    logic             grantValid;
    logic             grantLast;
    logic [7:0]       grantData;
    logic             grantOn;
    logic [16:0]      lenNext;
    logic             atMax;
    logic             gapLast;

    rr_picker #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) uPicker (
        .reqIn    (srcValidIn),
        .ptrIn    (rrPtr),
        .foundOut (pickFound),
        .idxOut   (pickIdx)
    );

    // Mux the granted source's stream.
    always_comb begin
        grantValid = 1'b0;
        grantLast  = 1'b0;
        grantData  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (IDX_W'(i) == grant) begin
                grantValid = srcValidIn[i];
                grantLast  = srcLastIn[i];
                grantData  = srcDataIn[8*i +: 8];
            end
        end
    end

    // Ready depends on state and grant only, never on valid.
    assign grantOn = (state == DATA) || (state == DRAIN);

    always_comb begin
        srcReadyOut = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grantOn && (IDX_W'(i) == grant)) begin
                srcReadyOut[i] = 1'b1;
            end
        end
    end

    assign lenNext = {1'b0, lenCnt} + 17'd1;
    assign atMax   = (lenNext == 17'(MAX_LEN));
    assign gapLast = (gapCnt == 8'(GAP_CYCLES - 1));
    assign busyOut = (state != IDLE);

    always_ff @(posedge wrClkIn) begin
        if (wrRstIn) begin
            state       <= IDLE;
            grant       <= '0;
            rrPtr       <= IDX_W'(NUM_SRC - 1);
            lenCnt      <= '0;
            gapCnt      <= '0;
            wrEnOut     <= 1'b0;
            wrDataOut   <= '0;
            truncCntOut <= '0;
        end else begin
            wrEnOut <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pickFound) begin
                        grant     <= pickIdx;
                        rrPtr     <= pickIdx;
                        wrEnOut   <= 1'b1;
                        wrDataOut <= mkHeader(4'(pickIdx));
                        lenCnt    <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (grantValid) begin
                        wrEnOut   <= 1'b1;
                        wrDataOut <= grantData;
                        lenCnt    <= lenNext[15:0];
                        // A last byte that is also the MAX_LENth is a clean end.
                        if (grantLast) begin
                            gapCnt <= '0;
                            state  <= END_STATE;
                        end else if (atMax) begin
                            state <= DRAIN;
                            if (truncCntOut != '1) begin
                                truncCntOut <= truncCntOut + 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (grantValid && grantLast) begin
                        gapCnt <= '0;
                        state  <= END_STATE;
                    end
                end
                GAP: begin
                    if (gapLast) begin
                        state <= IDLE;
                    end else begin
                        gapCnt <= gapCnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
